// File: rtl/sar_comparator_responder.sv
// sar_comparator_responder
// Digital stand-in for the comparator and sample-and-hold end of a SAR ADC
// interface. On a sample request it latches vin_code. For each DAC guess
// (sel) from the controller it answers with the add decision. When the
// controller raises done, it captures the final code.
//
// Optional build macro: SAR_RESP_STATS_EN adds the saturating conversion and
// timeout counters (conv_count, timeout_count).
//
// Parameters:
//   WIDTH        code width of vin_code / sel / result
//   CMP_LATENCY  register stages on add (1..4)
//   HOLD_CYCLES  max cycles spent in HOLD before timeout (2..255)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   sample_req    capture request, level sampled at posedge
//   vin_code      code to capture
//   sel           DAC guess from the SAR controller
//   done          controller conversion-complete flag
//   add           comparator decision (held > sel), CMP_LATENCY cycles late
//   busy          high while a conversion is held
//   result        sel captured when done is seen
//   result_valid  one-cycle pulse when result updates
//   timeout       one-cycle pulse when HOLD expires without done
//   conv_count    (SAR_RESP_STATS_EN) saturating count of result_valid pulses
//   timeout_count (SAR_RESP_STATS_EN) saturating count of timeout pulses
module sar_comparator_responder #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned CMP_LATENCY = 1,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_req,
    input  logic [WIDTH-1:0] vin_code,
    input  logic [WIDTH-1:0] sel,
    input  logic             done,
    output logic             add,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
`ifdef SAR_RESP_STATS_EN
    output logic [7:0]       conv_count,
    output logic [7:0]       timeout_count,
`endif
    output logic             timeout
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned STAT_W = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       held_q, held_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   rv_q, rv_d;
    logic                   to_q, to_d;
    logic [CMP_LATENCY-1:0] add_pipe_q, add_pipe_d;
    logic                   cmp_c;

    // Next-state and registered-output logic for the conversion FSM.
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        result_d = result_q;
        rv_d     = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample_req) begin
                    held_d  = vin_code;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                // done has priority over both the limit and a new sample_req.
                if (done) begin
                    result_d = sel;
                    rv_d     = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Comparator term; forced low outside HOLD.
    assign cmp_c = (state_q == S_HOLD) && (held_q > sel);

    // Pure shift-register delay on the decision, no bypass path.
    if (CMP_LATENCY == 1) begin : g_lat1
        assign add_pipe_d = cmp_c;
    end else begin : g_latn
        assign add_pipe_d = {add_pipe_q[CMP_LATENCY-2:0], cmp_c};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            held_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            result_q   <= '0;
            rv_q       <= 1'b0;
            to_q       <= 1'b0;
            add_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            result_q   <= result_d;
            rv_q       <= rv_d;
            to_q       <= to_d;
            add_pipe_q <= add_pipe_d;
        end
    end

    assign add          = add_pipe_q[CMP_LATENCY-1];
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign timeout      = to_q;

`ifdef SAR_RESP_STATS_EN
    logic [STAT_W-1:0] conv_q, conv_d;
    logic [STAT_W-1:0] tcnt_q, tcnt_d;

    // Saturating event counters, updated on the same edge that raises the pulse.
    always_comb begin
        conv_d = conv_q;
        tcnt_d = tcnt_q;
        if (rv_d && (conv_q != {STAT_W{1'b1}})) begin
            conv_d = conv_q + STAT_W'(1);
        end
        if (to_d && (tcnt_q != {STAT_W{1'b1}})) begin
            tcnt_d = tcnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_q <= '0;
            tcnt_q <= '0;
        end else begin
            conv_q <= conv_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign conv_count    = conv_q;
    assign timeout_count = tcnt_q;
`endif

endmodule

// File: tb/tb_sar_comparator_responder.sv
// Self-checking bench for sar_comparator_responder.
// dut_a: WIDTH=3, CMP_LATENCY=1, HOLD_CYCLES=16
// dut_b: WIDTH=3, CMP_LATENCY=3, HOLD_CYCLES=16 (latency and statistics)
// Expected add decisions and results are pushed to queues as stimulus is
// driven, and popped when the DUT is due to present them.
module tb_sar_comparator_responder;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    logic         a_sreq = 1'b0, a_done = 1'b0;
    logic [W-1:0] a_vin = '0, a_sel = '0;
    logic         a_add, a_busy, a_rv, a_to;
    logic [W-1:0] a_result;

    logic         b_sreq = 1'b0, b_done = 1'b0;
    logic [W-1:0] b_vin = '0, b_sel = '0;
    logic         b_add, b_busy, b_rv, b_to;
    logic [W-1:0] b_result;
`ifdef SAR_RESP_STATS_EN
    logic [7:0]   a_conv, a_tcnt, b_conv, b_tcnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_res_a[$];
    logic [W-1:0] exp_res_b[$];
    logic         exp_add[$];

    sar_comparator_responder #(.WIDTH(W), .CMP_LATENCY(1), .HOLD_CYCLES(16)) dut_a (
        .clk(clk), .reset(reset), .sample_req(a_sreq), .vin_code(a_vin),
        .sel(a_sel), .done(a_done), .add(a_add), .busy(a_busy),
        .result(a_result), .result_valid(a_rv),
`ifdef SAR_RESP_STATS_EN
        .conv_count(a_conv), .timeout_count(a_tcnt),
`endif
        .timeout(a_to)
    );

    sar_comparator_responder #(.WIDTH(W), .CMP_LATENCY(3), .HOLD_CYCLES(16)) dut_b (
        .clk(clk), .reset(reset), .sample_req(b_sreq), .vin_code(b_vin),
        .sel(b_sel), .done(b_done), .add(b_add), .busy(b_busy),
        .result(b_result), .result_valid(b_rv),
`ifdef SAR_RESP_STATS_EN
        .conv_count(b_conv), .timeout_count(b_tcnt),
`endif
        .timeout(b_to)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running (got running, expected finished)");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++; if (a_add !== 1'b0)    begin failures++; $display("FAIL reset_add: got %b expected 0", a_add); end
        checks++; if (a_busy !== 1'b0)   begin failures++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_result !== 3'd0) begin failures++; $display("FAIL reset_result: got %0d expected 0", a_result); end
        checks++; if (a_rv !== 1'b0)     begin failures++; $display("FAIL reset_rv: got %b expected 0", a_rv); end
        checks++; if (a_to !== 1'b0)     begin failures++; $display("FAIL reset_timeout: got %b expected 0", a_to); end
        checks++; if (b_add !== 1'b0)    begin failures++; $display("FAIL reset_b_add: got %b expected 0", b_add); end
`ifdef SAR_RESP_STATS_EN
        checks++; if (b_conv !== 8'd0 || b_tcnt !== 8'd0) begin failures++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", b_conv, b_tcnt); end
`endif
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    // Capture 5 and compare against sel=3 then sel=6.
    task automatic test_capture_compare;
        logic e;
        a_sreq = 1'b1; a_vin = 3'd5; a_sel = 3'd3;
        exp_add.push_back(1'b0);          // IDLE cycle before capture
        tick();
        e = exp_add.pop_front();
        checks++; if (a_add !== e)     begin failures++; $display("FAIL cap_add0: got %b expected %b", a_add, e); end
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL cap_busy: got %b expected 1", a_busy); end
        a_sreq = 1'b0;
        exp_add.push_back(1'b1);          // 5 > 3
        tick();
        e = exp_add.pop_front();
        checks++; if (a_add !== e)     begin failures++; $display("FAIL cap_add1: got %b expected %b", a_add, e); end
        a_sel = 3'd6;
        exp_add.push_back(1'b0);          // 5 > 6 false
        tick();
        e = exp_add.pop_front();
        checks++; if (a_add !== e)     begin failures++; $display("FAIL cap_add2: got %b expected %b", a_add, e); end
    endtask

    task automatic test_done;
        logic [W-1:0] r;
        a_sel = 3'd6; a_done = 1'b1;
        exp_res_a.push_back(3'd6);
        tick();
        a_done = 1'b0;
        checks++; if (a_rv !== 1'b1) begin failures++; $display("FAIL done_rv: got %b expected 1", a_rv); end
        if (a_rv === 1'b1 && exp_res_a.size() > 0) begin
            r = exp_res_a.pop_front();
            checks++; if (a_result !== r) begin failures++; $display("FAIL done_result: got %0d expected %0d", a_result, r); end
        end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL done_busy: got %b expected 0", a_busy); end
        checks++; if (a_add !== 1'b0)  begin failures++; $display("FAIL done_add: got %b expected 0", a_add); end
        tick();
        checks++; if (a_rv !== 1'b0)   begin failures++; $display("FAIL done_rv_pulse: got %b expected 0", a_rv); end
        checks++; if (a_add !== 1'b0)  begin failures++; $display("FAIL done_add_idle: got %b expected 0", a_add); end
    endtask

    task automatic test_timeout;
        a_sreq = 1'b1; a_vin = 3'd7; a_sel = 3'd0;
        tick();
        a_sreq = 1'b0;
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL to_busy_rise: got %b expected 1", a_busy); end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++;
            if ({a_to, a_busy} !== 2'b01) begin
                failures++; $display("FAIL to_early_%0d: got to/busy=%b%b expected 01", i, a_to, a_busy);
            end
        end
        tick();
        checks++; if ({a_to, a_busy, a_rv} !== 3'b100) begin failures++; $display("FAIL to_pulse: got to/busy/rv=%b%b%b expected 100", a_to, a_busy, a_rv); end
        checks++; if (a_result !== 3'd6) begin failures++; $display("FAIL to_result_kept: got %0d expected 6", a_result); end
        tick();
        checks++; if ({a_to, a_rv} !== 2'b00) begin failures++; $display("FAIL to_pulse_width: got to/rv=%b%b expected 00", a_to, a_rv); end
    endtask

    // sample_req mid-HOLD is ignored; done beats a simultaneous sample_req.
    task automatic test_no_overwrite;
        logic [W-1:0] r;
        a_sreq = 1'b1; a_vin = 3'd5; a_sel = 3'd4;
        tick();
        a_vin = 3'd2;                     // sample_req stays high during HOLD
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (a_add !== 1'b1) begin failures++; $display("FAIL hold_add_%0d: got %b expected 1", i, a_add); end
        end
        a_done = 1'b1;
        exp_res_a.push_back(3'd4);
        tick();
        a_done = 1'b0; a_sreq = 1'b0;
        checks++; if (a_rv !== 1'b1)   begin failures++; $display("FAIL race_rv: got %b expected 1", a_rv); end
        if (a_rv === 1'b1 && exp_res_a.size() > 0) begin
            r = exp_res_a.pop_front();
            checks++; if (a_result !== r) begin failures++; $display("FAIL race_result: got %0d expected %0d", a_result, r); end
        end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL race_busy: got %b expected 0", a_busy); end
        tick();
        tick();
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL race_no_capture: got %b expected 0", a_busy); end
        checks++; if (a_add !== 1'b0)  begin failures++; $display("FAIL race_add_idle: got %b expected 0", a_add); end
    endtask

    task automatic test_reset_midhold;
        a_sreq = 1'b1; a_vin = 3'd5; a_sel = 3'd3;
        tick();
        a_sreq = 1'b0;
        tick();
        checks++; if ({a_add, a_busy} !== 2'b11) begin failures++; $display("FAIL rst_pre: got add/busy=%b%b expected 11", a_add, a_busy); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({a_add, a_busy, a_rv, a_to} !== 4'b0000) begin failures++; $display("FAIL rst_async: got add/busy/rv/to=%b%b%b%b expected 0000", a_add, a_busy, a_rv, a_to); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++; if (a_result !== 3'd0) begin failures++; $display("FAIL rst_result: got %0d expected 0", a_result); end
        checks++; if (a_busy !== 1'b0)   begin failures++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
        a_done = 1'b1;                    // done in IDLE is ignored
        tick();
        a_done = 1'b0;
        checks++; if ({a_rv, a_to, a_busy} !== 3'b000) begin failures++; $display("FAIL rst_idle_done: got rv/to/busy=%b%b%b expected 000", a_rv, a_to, a_busy); end
    endtask

    // held=4, sel toggles 2/6: add shows 1,0,... three cycles later.
    task automatic test_latency3;
        logic         e;
        logic [W-1:0] r;
        logic [W-1:0] sel_seq [13];
        logic         req_seq [13];
        logic         c_seq   [13];
        for (int i = 0; i < 13; i++) begin
            sel_seq[i] = 3'd6; req_seq[i] = 1'b0; c_seq[i] = 1'b0;
        end
        sel_seq[2] = 3'd2; req_seq[2] = 1'b1;
        for (int i = 3; i < 11; i++) begin
            sel_seq[i] = ((i % 2) == 1) ? 3'd2 : 3'd6;
            c_seq[i]   = ((i % 2) == 1) ? 1'b1 : 1'b0;
        end
        b_vin = 3'd4;
        for (int i = 0; i < 13; i++) begin
            b_sreq = req_seq[i]; b_sel = sel_seq[i];
            exp_add.push_back(c_seq[i]);
            tick();
            if (exp_add.size() >= 3) begin
                e = exp_add.pop_front();
                checks++; if (b_add !== e) begin failures++; $display("FAIL lat3_add_%0d: got %b expected %b", i, b_add, e); end
            end
        end
        exp_add.delete();
        b_done = 1'b1; b_sel = 3'd5;
        exp_res_b.push_back(3'd5);
        tick();
        b_done = 1'b0;
        checks++; if (b_rv !== 1'b1) begin failures++; $display("FAIL lat3_rv: got %b expected 1", b_rv); end
        if (b_rv === 1'b1 && exp_res_b.size() > 0) begin
            r = exp_res_b.pop_front();
            checks++; if (b_result !== r) begin failures++; $display("FAIL lat3_result: got %0d expected %0d", b_result, r); end
        end
        tick();
    endtask

    // Two more conversions and one timeout on dut_b.
    task automatic test_stats;
        logic [W-1:0] r;
        for (int k = 0; k < 2; k++) begin
            b_sreq = 1'b1; b_vin = 3'd1; b_sel = 3'd0;
            tick();
            b_sreq = 1'b0;
            tick();
            b_done = 1'b1; b_sel = W'(k + 2);
            exp_res_b.push_back(W'(k + 2));
            tick();
            b_done = 1'b0;
            checks++; if (b_rv !== 1'b1) begin failures++; $display("FAIL stats_rv_%0d: got %b expected 1", k, b_rv); end
            if (b_rv === 1'b1 && exp_res_b.size() > 0) begin
                r = exp_res_b.pop_front();
                checks++; if (b_result !== r) begin failures++; $display("FAIL stats_result_%0d: got %0d expected %0d", k, b_result, r); end
            end
            tick();
        end
        b_sreq = 1'b1;
        tick();
        b_sreq = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        tick();
        checks++; if ({b_to, b_rv} !== 2'b10) begin failures++; $display("FAIL stats_timeout: got to/rv=%b%b expected 10", b_to, b_rv); end
        tick();
`ifdef SAR_RESP_STATS_EN
        checks++; if (b_conv !== 8'd3) begin failures++; $display("FAIL stats_conv_count: got %0d expected 3", b_conv); end
        checks++; if (b_tcnt !== 8'd1) begin failures++; $display("FAIL stats_timeout_count: got %0d expected 1", b_tcnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_capture_compare();
        test_done();
        test_timeout();
        test_no_overwrite();
        test_reset_midhold();
        test_latency3();
        test_stats();
        checks++;
        if (exp_res_a.size() != 0 || exp_res_b.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", exp_res_a.size(), exp_res_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_comparator_responder.md
Name: sar_comparator_responder

Overview:
Digital responder for the SAR ADC controller. It models the comparator/sample-and-hold end of the SAR interface.
- Captures an input code on request and holds it for one conversion.
- Answers each DAC guess (sel) with the add decision: 1 = guess too low.
- Collects the final code when the controller signals done.
- Sits between stimulus/test logic and the SAR controller. Its add output drives the controller's add input; the controller's sel/done drive this block.

Parameters:
WIDTH, 3, code width of vin_code/sel/result
CMP_LATENCY, 1, register stages on add (legal 1..4)
HOLD_CYCLES, 16, max cycles in HOLD before timeout (legal 2..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
sample_req  input  1  request to capture vin_code (level, sampled at posedge)
vin_code  input  WIDTH  digital stand-in for analog input
sel  input  WIDTH  DAC code from SAR controller
done  input  1  controller conversion-complete flag
add  output  1  comparator decision (held > sel), delayed CMP_LATENCY
busy  output  1  1 while in HOLD
result  output  WIDTH  sel captured at conversion end
result_valid  output  1  one-cycle pulse when result updates
timeout  output  1  one-cycle pulse when HOLD expires without done

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, held=0, hold counter=0, add pipeline all 0, add=0, busy=0, result=0, result_valid=0, timeout=0.
- States:
  - IDLE
    - sample_req=1 at an edge: held<=vin_code, counter<=0, -> HOLD.
    - Otherwise stay.
  - HOLD: counter increments each edge.
    - done=1 at an edge: result<=sel, result_valid=1 for the following cycle, -> IDLE.
    - Else, if counter==HOLD_CYCLES-1: timeout=1 for the following cycle, result unchanged, -> IDLE.
    - HOLD therefore lasts at most HOLD_CYCLES cycles.
- sample_req in HOLD is ignored; held is never overwritten mid-conversion.
- done and sample_req at the same HOLD edge: done wins, -> IDLE, no capture; sample_req must be seen again in IDLE.
- done and counter limit at the same edge: done wins; no timeout.
- done in IDLE is ignored.
- Compare term c(t) = (state==HOLD) && (held > sel), unsigned, WIDTH bits. It is 0 in IDLE.
- add during cycle t+CMP_LATENCY equals c(t). This is a shift-register pipeline with no bypass.
- busy is registered: 1 in the cycle after the capture edge, 0 in the cycle after the done/timeout edge.
- result_valid and timeout are never high together and never wider than one cycle.
- Reset mid-HOLD aborts the conversion: no result_valid, no timeout, and the pipeline is flushed to 0.

Optional Feature:
SAR_RESP_STATS_EN
- Defined: adds outputs conv_count[7:0] and timeout_count[7:0], both reset to 0.
  - conv_count increments on each result_valid.
  - timeout_count increments on each timeout.
  - Both saturate at 255.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
1. Assert reset between clock edges while in HOLD with add=1 -> add, busy, result_valid and timeout go to 0 immediately. After release, state is IDLE and result=0.
2. WIDTH=3, CMP_LATENCY=1; sample_req with vin_code=5 at edge N, sel=3 -> busy=1 after edge N and add=1 after edge N+1. Change sel to 6 -> add=0 one edge later.
3. In HOLD with sel=6, assert done -> result=6 and result_valid=1 for exactly one cycle, then busy=0 and add=0 after CMP_LATENCY edges.
4. HOLD_CYCLES=16, capture then never assert done -> timeout pulses once, 16 cycles after busy rises. busy=0, result unchanged, result_valid stays 0.
5. Held=5, assert sample_req with vin_code=2 mid-HOLD -> held stays 5 (add against sel=4 stays 1). Assert done and sample_req at the same edge -> IDLE, no new capture, busy=0.
6. CMP_LATENCY=3, toggle sel between 2 and 6 with held=4 -> add follows the pattern 1,0 delayed by exactly 3 cycles. With SAR_RESP_STATS_EN, 3 conversions plus 1 timeout -> conv_count=3, timeout_count=1.
